// File: rtl/pipeline_flow_elastic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_flow_elastic_pkg
// Purpose  : Shared width helpers for the elastic flow controller and the
//            units that instantiate it.
// Revision : 1.0  initial release
// ============================================================================
package pipeline_flow_elastic_pkg;

    // Width of the occupancy counter: it must represent 0..stages+depth.
    function automatic int gfx_flow_count_w(input int stages, input int depth);
        return $clog2(stages + depth + 1);
    endfunction

    // Pointer width of a power-of-two circular buffer (at least one bit).
    function automatic int skid_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_skid_fifo
// Purpose  : Small circular skid buffer holding the tail stage's data.
//            Synchronous clear drops all entries; reset also zeroes storage.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_skid_fifo
    import pipeline_flow_elastic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = skid_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (fifo_cnt == CNT_W'(DEPTH));
    assign empty   = (fifo_cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage: zeroed only by reset; a clear leaves stale data behind invalid slots.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_flow_elastic.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_flow_elastic
// Purpose  : Elastic flow controller. Produces per-stage load enables so
//            bubbles collapse, buffers the tail in a skid FIFO so out_ready
//            never reaches in_ready/stage_en, supports flush and tracks
//            total occupancy.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_flow_elastic
    import pipeline_flow_elastic_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int WIDTH      = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic                                             flush,
    output logic [STAGES-1:0]                                stage_en,
    output logic [STAGES-1:0]                                stage_valid,
    input  logic [WIDTH-1:0]                                 tail_data,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [WIDTH-1:0]                                 out_data,
    output logic [gfx_flow_count_w(STAGES, SKID_DEPTH)-1:0]  count
);

    localparam int CNT_W = gfx_flow_count_w(STAGES, SKID_DEPTH);

    logic [STAGES-1:0] chain_en;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              accept;

    // The tail only pushes into a slot that was free at the start of the cycle.
    assign push      = stage_valid[STAGES-1] && !fifo_full;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign in_ready  = chain_en[0] && !flush;
    assign accept    = in_valid && in_ready;
    assign stage_en  = chain_en | {STAGES{flush}};

    // Enable ripple from the tail: a stage moves when empty or when its successor moves.
    always_comb begin
        chain_en             = '0;
        chain_en[STAGES-1]   = !stage_valid[STAGES-1] || push;
        for (int i = STAGES - 2; i >= 0; i--) begin
            chain_en[i] = !stage_valid[i] || chain_en[i+1];
        end
    end

    // Valid chain: each enabled stage takes its predecessor's valid.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            stage_valid <= '0;
        end else begin
            if (chain_en[0]) begin
                stage_valid[0] <= in_valid;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (chain_en[i]) begin
                    stage_valid[i] <= stage_valid[i-1];
                end
            end
        end
    end

    // Occupancy: stages plus FIFO, tracked from accepts and pops.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    pipeline_skid_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .wdata (tail_data),
        .pop   (pop),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
`default_nettype wire
